// File: rtl/game_frame_controller_pkg.sv
// Shared definitions for the game frame controller:
// FSM states, direction bit positions and default parameters.
package game_pkg;

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_PAUSE   = 2'd2
    } state_e;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int DEF_GRID_DIM     = 4;
    localparam int DEF_TILE_W       = 4;
    localparam int DEF_HL_FRAMES    = 25;
    localparam int DEF_NUM_PALETTES = 2;

    // Collapse simultaneous direction edges: up > right > down > left.
    function automatic logic [3:0] dir_pick(input logic [3:0] r);
        logic [3:0] m;
        m = '0;
        if (r[DIR_UP])         m[DIR_UP]    = 1'b1;
        else if (r[DIR_RIGHT]) m[DIR_RIGHT] = 1'b1;
        else if (r[DIR_DOWN])  m[DIR_DOWN]  = 1'b1;
        else if (r[DIR_LEFT])  m[DIR_LEFT]  = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/game_frame_controller_if.sv
// Renderer-facing output bundle of the frame controller.
// master drives it, slave (renderer / checker) consumes it.
interface game_frame_controller_if #(
    parameter int NT     = 16,
    parameter int TILE_W = 4,
    parameter int PW     = 1
);
    logic [NT*TILE_W-1:0] display_grid;
    logic [3:0]           move_dir;
    logic                 game_start;
    logic                 show_welcome;
    logic                 paused;
    logic [NT-1:0]        hl_mask;
    logic [2:0]           hl_phase;
    logic [PW-1:0]        palette_sel;

    modport master (
        output display_grid, move_dir, game_start, show_welcome,
        output paused, hl_mask, hl_phase, palette_sel
    );

    modport slave (
        input display_grid, move_dir, game_start, show_welcome,
        input paused, hl_mask, hl_phase, palette_sel
    );
endinterface

// File: rtl/game_frame_controller_rise.sv
// Rising-edge detector; previous level resets high so that
// inputs held through reset produce no edge.
module rise_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= '1;
        else        prev_q <= lvl_i;
    end

    assign rise_o = lvl_i & ~prev_q;
endmodule

// File: rtl/game_frame_controller.sv
// Frame controller: welcome/play/pause FSM, frame-stable grid,
// move strobes, per-tile highlight timers and palette select.
module game_frame_controller
    import game_pkg::*;
#(
    parameter int GRID_DIM     = DEF_GRID_DIM,
    parameter int TILE_W       = DEF_TILE_W,
    parameter int HL_FRAMES    = DEF_HL_FRAMES,
    parameter int NUM_PALETTES = DEF_NUM_PALETTES,
    localparam int NT = GRID_DIM * GRID_DIM,
    localparam int IW = (NT > 1) ? $clog2(NT) : 1,
    localparam int PW = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic [3:0]           btn_dir,
    input  logic                 btn_start,
    input  logic                 btn_select,
    input  logic [NT*TILE_W-1:0] welcome_grid,
    input  logic [NT*TILE_W-1:0] logic_grid,
    input  logic                 added_valid,
    input  logic [IW-1:0]        added_index,
    output logic [NT*TILE_W-1:0] display_grid,
    output logic [3:0]           move_dir,
    output logic                 game_start,
    output logic                 show_welcome,
    output logic                 paused,
    output logic [NT-1:0]        hl_mask,
    output logic [2:0]           hl_phase,
    output logic [PW-1:0]        palette_sel
);
    logic [5:0] rise;
    logic [3:0] dir_r;
    logic       start_r;
    logic       sel_r;

    rise_detect #(.W(6)) u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  ({btn_select, btn_start, btn_dir}),
        .rise_o (rise)
    );

    assign dir_r   = rise[3:0];
    assign start_r = rise[4];
    assign sel_r   = rise[5];

    logic vsync_prev_q;
    logic frame_edge;

    assign frame_edge = vsync & ~vsync_prev_q;

    state_e               state_q;
    logic                 exit_pending_q;
    logic [NT*TILE_W-1:0] display_q;
    logic [3:0]           move_dir_q;
    logic                 game_start_q;
    logic                 show_welcome_q;
    logic                 paused_q;
    logic [PW-1:0]        pal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev_q   <= 1'b0;
            state_q        <= ST_WELCOME;
            exit_pending_q <= 1'b0;
            display_q      <= '0;
            move_dir_q     <= '0;
            game_start_q   <= 1'b0;
            show_welcome_q <= 1'b1;
            paused_q       <= 1'b0;
            pal_q          <= '0;
        end else begin
            vsync_prev_q <= vsync;
            move_dir_q   <= '0;
            game_start_q <= 1'b0;
            if (sel_r) begin
                if (pal_q == PW'(NUM_PALETTES - 1)) pal_q <= '0;
                else                                pal_q <= pal_q + PW'(1);
            end
            unique case (state_q)
                ST_WELCOME: begin
                    if (frame_edge) display_q <= welcome_grid;
                    // The leaving edge already shows the game grid.
                    if (frame_edge && exit_pending_q) begin
                        state_q        <= ST_PLAY;
                        exit_pending_q <= 1'b0;
                        show_welcome_q <= 1'b0;
                        display_q      <= logic_grid;
                    end else if ((|dir_r) || start_r) begin
                        exit_pending_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (frame_edge) display_q <= logic_grid;
                    if (start_r) begin
                        state_q  <= ST_PAUSE;
                        paused_q <= 1'b1;
                    end else if (|dir_r) begin
                        move_dir_q <= dir_pick(dir_r);
                    end
                end
                ST_PAUSE: begin
                    if (start_r) begin
                        state_q      <= ST_PLAY;
                        paused_q     <= 1'b0;
                        game_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_WELCOME;
                    show_welcome_q <= 1'b1;
                    paused_q       <= 1'b0;
                end
            endcase
        end
    end

    logic [7:0]    cnt_q [NT];
    logic [7:0]    cnt_d [NT];
    logic [IW-1:0] newest_q;
    logic [IW-1:0] newest_d;
    logic [NT-1:0] hl_mask_d;
    logic [NT-1:0] hl_mask_q;
    logic [2:0]    hl_phase_d;
    logic [2:0]    hl_phase_q;

    // Mask and phase register the next counter values so they
    // stay aligned with the counters themselves.
    always_comb begin
        newest_d = added_valid ? added_index : newest_q;
        for (int i = 0; i < NT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (added_valid && (added_index == IW'(i))) begin
                cnt_d[i] = 8'(HL_FRAMES);
            end else if (frame_edge && (state_q != ST_PAUSE)
                         && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            hl_mask_d[i] = (cnt_d[i] != 8'd0);
        end
        hl_phase_d = cnt_d[newest_d][3:1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) cnt_q[i] <= 8'd0;
            newest_q   <= '0;
            hl_mask_q  <= '0;
            hl_phase_q <= 3'd0;
        end else begin
            for (int i = 0; i < NT; i++) cnt_q[i] <= cnt_d[i];
            newest_q   <= newest_d;
            hl_mask_q  <= hl_mask_d;
            hl_phase_q <= hl_phase_d;
        end
    end

    assign display_grid = display_q;
    assign move_dir     = move_dir_q;
    assign game_start   = game_start_q;
    assign show_welcome = show_welcome_q;
    assign paused       = paused_q;
    assign hl_mask      = hl_mask_q;
    assign hl_phase     = hl_phase_q;
    assign palette_sel  = pal_q;
endmodule

// File: tb/tb_game_frame_controller.sv
// Directed bench for game_frame_controller: default instance plus
// a 5x5 / 3-palette / HL_FRAMES=10 instance.
module tb_game_frame_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vsync;
    logic [3:0]  btn_dir;
    logic        btn_start;
    logic        btn_select;

    logic [63:0] wg;
    logic [63:0] lg;
    logic        av;
    logic [3:0]  ai;

    logic [99:0] wg2;
    logic [99:0] lg2;
    logic        av2;
    logic [4:0]  ai2;
    logic [99:0] dg2;
    logic [3:0]  md2;
    logic        gs2;
    logic        sw2;
    logic        p2;
    logic [24:0] hm2;
    logic [2:0]  hp2;
    logic [1:0]  ps2;

    game_frame_controller_if #(.NT(16), .TILE_W(4), .PW(1)) vif ();

    game_frame_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .btn_dir      (btn_dir),
        .btn_start    (btn_start),
        .btn_select   (btn_select),
        .welcome_grid (wg),
        .logic_grid   (lg),
        .added_valid  (av),
        .added_index  (ai),
        .display_grid (vif.display_grid),
        .move_dir     (vif.move_dir),
        .game_start   (vif.game_start),
        .show_welcome (vif.show_welcome),
        .paused       (vif.paused),
        .hl_mask      (vif.hl_mask),
        .hl_phase     (vif.hl_phase),
        .palette_sel  (vif.palette_sel)
    );

    game_frame_controller #(
        .GRID_DIM(5), .TILE_W(4), .HL_FRAMES(10), .NUM_PALETTES(3)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .btn_dir      (btn_dir),
        .btn_start    (btn_start),
        .btn_select   (btn_select),
        .welcome_grid (wg2),
        .logic_grid   (lg2),
        .added_valid  (av2),
        .added_index  (ai2),
        .display_grid (dg2),
        .move_dir     (md2),
        .game_start   (gs2),
        .show_welcome (sw2),
        .paused       (p2),
        .hl_mask      (hm2),
        .hl_phase     (hp2),
        .palette_sel  (ps2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One vsync pulse; edge seen at the first posedge.
    task automatic frame();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] dir;
        logic       st;
        logic [3:0] mv;
        logic       ps;
        logic       gs;
    } vec_t;

    vec_t v [20];

    int cnt;
    int cnt2;
    int p1;
    int p3;
    logic [63:0] l2;

    initial begin
        v[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 1'b0};
        v[2]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[4]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0};
        v[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[6]  = '{4'b0110, 1'b0, 4'b0010, 1'b0, 1'b0};
        v[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0};
        v[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[10] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0};
        v[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        v[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        v[14] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        v[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        v[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1};
        v[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        v[18] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0};
        v[19] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

        rst_n      = 1'b0;
        vsync      = 1'b0;
        btn_dir    = 4'b0001;
        btn_start  = 1'b0;
        btn_select = 1'b0;
        wg  = 64'h1111_2222_3333_4444;
        lg  = 64'h0123_4567_89ab_cdef;
        av  = 1'b0;
        ai  = 4'd0;
        wg2 = {25{4'h5}};
        lg2 = {25{4'ha}};
        av2 = 1'b0;
        ai2 = 5'd0;
        repeat (2) @(negedge clk);

        chk("rst_welcome", vif.show_welcome, 1);
        chk("rst_paused", vif.paused, 0);
        chk("rst_move", vif.move_dir, 0);
        chk("rst_gstart", vif.game_start, 0);
        chk("rst_display", vif.display_grid, 0);
        chk("rst_hlmask", vif.hl_mask, 0);
        chk("rst_palette", vif.palette_sel, 0);
        chk("rst_welcome2", sw2, 1);

        rst_n = 1'b1;
        @(negedge clk);
        chk("held_btn_move", vif.move_dir, 0);
        btn_dir = 4'b0000;
        @(negedge clk);
        frame();
        chk("welcome_grid_load", vif.display_grid, wg);
        chk("welcome_stay", vif.show_welcome, 1);

        btn_dir = 4'b0001;
        @(negedge clk);
        chk("welcome_press_move", vif.move_dir, 0);
        chk("welcome_press_gs", vif.game_start, 0);
        btn_dir = 4'b0000;
        @(negedge clk);
        chk("welcome_until_edge", vif.show_welcome, 1);
        frame();
        chk("exit_welcome", vif.show_welcome, 0);
        chk("exit_display", vif.display_grid, lg);
        chk("exit_display2", dg2, lg2);

        for (int i = 0; i < 20; i++) begin
            btn_dir   = v[i].dir;
            btn_start = v[i].st;
            @(negedge clk);
            chk($sformatf("vec%0d_move", i), vif.move_dir, v[i].mv);
            chk($sformatf("vec%0d_paused", i), vif.paused, v[i].ps);
            chk($sformatf("vec%0d_gstart", i), vif.game_start, v[i].gs);
        end
        btn_dir   = 4'b0000;
        btn_start = 1'b0;

        av = 1'b1;
        ai = 4'd0;
        @(negedge clk);
        av  = 1'b0;
        cnt = 25;
        chk("hl0_load_mask", vif.hl_mask, 16'h0001);
        chk("hl0_load_phase", vif.hl_phase, (cnt >> 1) & 7);
        for (int f = 0; f < 26; f++) begin
            frame();
            if (cnt > 0) cnt--;
            chk($sformatf("hl0_f%0d_mask", f), vif.hl_mask,
                (cnt != 0) ? 16'h0001 : 16'h0000);
            chk($sformatf("hl0_f%0d_phase", f), vif.hl_phase,
                (cnt >> 1) & 7);
        end

        av = 1'b1;
        ai = 4'd5;
        @(negedge clk);
        av  = 1'b0;
        cnt = 25;
        frame();
        frame();
        cnt = cnt - 2;
        l2 = 64'hfeed_beef_0bad_f00d;
        lg = l2;
        frame();
        cnt--;
        chk("pre_pause_display", vif.display_grid, l2);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        chk("pause_enter", vif.paused, 1);
        lg = 64'h5a5a_a5a5_3c3c_c3c3;
        for (int f = 0; f < 3; f++) begin
            frame();
            chk($sformatf("pause_f%0d_display", f), vif.display_grid, l2);
            chk($sformatf("pause_f%0d_mask", f), vif.hl_mask, 16'h0020);
            chk($sformatf("pause_f%0d_phase", f), vif.hl_phase,
                (cnt >> 1) & 7);
        end
        btn_start = 1'b1;
        @(negedge clk);
        chk("resume_gstart", vif.game_start, 1);
        chk("resume_paused", vif.paused, 0);
        btn_start = 1'b0;
        @(negedge clk);
        chk("resume_gstart_once", vif.game_start, 0);
        frame();
        cnt--;
        chk("resume_phase", vif.hl_phase, (cnt >> 1) & 7);
        chk("resume_display", vif.display_grid, lg);

        p1 = 0;
        p3 = 0;
        for (int k = 0; k < 4; k++) begin
            btn_select = 1'b1;
            @(negedge clk);
            p1 = (p1 + 1) % 2;
            p3 = (p3 + 1) % 3;
            chk($sformatf("pal2_press%0d", k), vif.palette_sel, p1);
            chk($sformatf("pal3_press%0d", k), ps2, p3);
            btn_select = 1'b0;
            @(negedge clk);
        end

        av2   = 1'b1;
        ai2   = 5'd24;
        vsync = 1'b1;
        @(negedge clk);
        av2   = 1'b0;
        vsync = 1'b0;
        cnt2  = 10;
        chk("coincide_mask24", hm2, 128'(1) << 24);
        chk("coincide_phase24", hp2, (cnt2 >> 1) & 7);
        @(negedge clk);
        for (int f = 0; f < 10; f++) begin
            frame();
            cnt2--;
            chk($sformatf("t24_f%0d_mask", f), hm2,
                (cnt2 != 0) ? (128'(1) << 24) : 128'(0));
        end

        chk("pre_reset_hl", vif.hl_mask, 16'h0020);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_hlmask", vif.hl_mask, 0);
        chk("midrst_welcome", vif.show_welcome, 1);
        chk("midrst_palette", vif.palette_sel, 0);
        chk("midrst_display", vif.display_grid, 0);
        chk("midrst_hlmask2", hm2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_frame_controller.md
GAME_FRAME_CONTROLLER -- requirements
Module: game_frame_controller

Interface
REQ-001 SHALL have parameter GRID_DIM, default 4, meaning tiles per grid side; NT = GRID_DIM*GRID_DIM.
REQ-002 SHALL have parameter TILE_W, default 4, meaning bits per tile exponent code.
REQ-003 SHALL have parameter HL_FRAMES, default 25, meaning new-tile highlight duration in frames (1..255).
REQ-004 SHALL have parameter NUM_PALETTES, default 2, meaning selectable colour palettes (1..8).
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- vsync  in  1  VGA vsync level.
- btn_dir  in  4  debounced direction levels [0]=up [1]=down [2]=left [3]=right.
- btn_start  in  1  start/pause level.
- btn_select  in  1  palette button level.
- welcome_grid  in  NT*TILE_W  attract-screen grid.
- logic_grid  in  NT*TILE_W  game-logic grid.
- added_valid  in  1  one-cycle strobe, tile added.
- added_index  in  clog2(NT)  index of the added tile.
- display_grid  out  NT*TILE_W  frame-stable grid for the renderer.
- move_dir  out  4  one-hot one-cycle move strobe.
- game_start  out  1  one-cycle strobe to game logic.
- show_welcome  out  1  high in WELCOME state.
- paused  out  1  high in PAUSE state.
- hl_mask  out  NT  per-tile highlight active.
- hl_phase  out  3  animation phase of the most recently added tile.
- palette_sel  out  clog2(NUM_PALETTES), minimum 1 bit  current palette.

Function
REQ-006 SHALL register vsync into vsync_prev; frame_edge = vsync & ~vsync_prev.
REQ-007 SHALL detect rising edges of each btn_dir bit, btn_start and btn_select against registered previous levels.
REQ-008 SHALL implement FSM states WELCOME, PLAY and PAUSE.
REQ-009 In WELCOME, any dir or start rising edge SHALL set exit_pending; at the next frame_edge with exit_pending set, the FSM SHALL enter PLAY and clear exit_pending.
REQ-010 The press that sets exit_pending SHALL produce no move_dir or game_start strobe.
REQ-011 In PLAY, a start rising edge SHALL enter PAUSE immediately; in PAUSE, a start rising edge SHALL return to PLAY.
REQ-012 In PLAY, a dir rising edge SHALL raise move_dir for exactly one cycle, the cycle after the edge.
REQ-013 Simultaneous dir edges SHALL resolve with priority up > right > down > left, producing a single one-hot pulse.
REQ-014 game_start SHALL pulse one cycle on PAUSE->PLAY; it SHALL be 0 in all other cycles.
REQ-015 move_dir SHALL be 0 in WELCOME and PAUSE.
REQ-016 On frame_edge, display_grid SHALL load welcome_grid in WELCOME, load logic_grid in PLAY, and hold in PAUSE; otherwise it SHALL hold.
REQ-017 Each tile SHALL have an 8-bit highlight counter; added_valid SHALL load counter[added_index] with HL_FRAMES and record added_index as newest.
REQ-018 Index 0 SHALL be a valid added_index.
REQ-019 On frame_edge, every nonzero counter SHALL decrement by 1, except in PAUSE, where counters freeze.
REQ-020 When added_valid and frame_edge coincide, the load SHALL win for that tile.
REQ-021 hl_mask[i] SHALL equal (counter[i] != 0).
REQ-022 hl_phase SHALL equal counter[newest][3:1].
REQ-023 A btn_select rising edge SHALL advance palette_sel modulo NUM_PALETTES in any state.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On reset: state=WELCOME, exit_pending=0, vsync_prev=0, display_grid=0, all counters=0, newest=0, palette_sel=0, move_dir=0, game_start=0.
REQ-026 Button previous-level registers SHALL reset to 1, so that buttons held through reset do not fire.
REQ-027 Reset mid-frame or mid-highlight SHALL override all pending actions within one cycle.

Structure
REQ-028 Package game_pkg SHALL hold the FSM state enum, direction bit index constants and the default parameter values.
REQ-029 The design SHALL instantiate sub-module rise_detect (parametrised width, reset-to-1 previous register) for the button edges.

Verification
REQ-030 Reset with btn_dir=4'b0001 held, then release and press up in WELCOME -> no move_dir; show_welcome falls at the next frame_edge; display_grid tracks logic_grid from that edge.
REQ-031 In PLAY, up and left rise in the same cycle -> move_dir=4'b0001 for exactly one cycle.
REQ-032 added_valid with added_index=0 -> hl_mask[0]=1 for exactly 25 frame_edges, then 0; hl_phase sequence 4,4,3,...,0.
REQ-033 In PLAY, start pressed -> paused=1, display_grid and counters frozen across 3 frames; start again -> game_start pulses once, counters resume.
REQ-034 With NUM_PALETTES=3, four select presses -> palette_sel sequence 1,2,0,1.
REQ-035 With GRID_DIM=5, added_valid on added_index=24 coinciding with frame_edge -> counter[24]=HL_FRAMES.
